// File: rtl/dispatch_issue_scoreboard.sv
// N-way in-order dispatch stage with a per-register scoreboard and registered issue.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data into operand reads.

module dispatch_issue_lane #(
  parameter int ISSUE_W = 2,
  parameter int XLEN    = 32,
  parameter int RAW     = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic [2:0]              op,
  input  logic [RAW-1:0]          rd,
  input  logic [RAW-1:0]          rs1,
  input  logic [RAW-1:0]          rs2,
  input  logic [XLEN-1:0]         imm,
  input  logic [XLEN-1:0]         rdata1,
  input  logic [XLEN-1:0]         rdata2,
  input  logic [3:0]              fu_busy,
  input  logic [ISSUE_W-1:0]      wb_valid,
  input  logic [RAW*ISSUE_W-1:0]  wb_rd,
  input  logic [XLEN*ISSUE_W-1:0] wb_data,
  output logic                    writer,
  output logic                    use1,
  output logic                    use2,
  output logic                    byp1,
  output logic                    byp2,
  output logic                    fu_block,
  output logic                    issue_valid,
  output logic [2:0]              issue_op,
  output logic [RAW-1:0]          issue_rd,
  output logic [XLEN-1:0]         issue_a,
  output logic [XLEN-1:0]         issue_b
);
  logic is_add, is_mul, is_ld, is_st;
  logic [XLEN-1:0] src1, src2, a_d, b_d;
  logic [2:0] op_d;

  assign is_add = (op == 3'd1);
  assign is_mul = (op == 3'd2);
  assign is_ld  = (op == 3'd3);
  assign is_st  = (op == 3'd4);

  assign writer   = is_add | is_mul | is_ld;
  assign use1     = is_add | is_mul | is_ld | is_st;
  assign use2     = is_add | is_mul | is_st;
  assign fu_block = (is_add & fu_busy[0]) | (is_mul & fu_busy[1]) |
                    (is_ld & fu_busy[2]) | (is_st & fu_busy[3]);

`ifdef WB_BYPASS_EN
  // Later lanes override earlier ones, so the highest matching lane wins.
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
    src1 = rdata1;
    src2 = rdata2;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (wb_valid[k] && wb_rd[k*RAW +: RAW] == rs1 && rs1 != '0) begin
        byp1 = 1'b1;
        src1 = wb_data[k*XLEN +: XLEN];
      end
      if (wb_valid[k] && wb_rd[k*RAW +: RAW] == rs2 && rs2 != '0) begin
        byp2 = 1'b1;
        src2 = wb_data[k*XLEN +: XLEN];
      end
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_rd, wb_data, rs1, rs2};
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign src1 = rdata1;
  assign src2 = rdata2;
`endif

  always_comb begin
    a_d  = '0;
    b_d  = '0;
    op_d = 3'd0;
    case (op)
      3'd1, 3'd2: begin a_d = src1;       b_d = src2; op_d = op; end
      3'd3:       begin a_d = src1 + imm;             op_d = op; end
      3'd4:       begin a_d = src1 + imm; b_d = src2; op_d = op; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_op    <= '0;
      issue_rd    <= '0;
      issue_a     <= '0;
      issue_b     <= '0;
    end else begin
      issue_valid <= go;
      issue_op    <= go ? op_d : 3'd0;
      issue_rd    <= go ? rd   : '0;
      issue_a     <= go ? a_d  : '0;
      issue_b     <= go ? b_d  : '0;
    end
  end
endmodule

module dispatch_issue_scoreboard #(
  parameter  int ISSUE_W  = 2,
  parameter  int NUM_REGS = 32,
  parameter  int XLEN     = 32,
  localparam int RAW      = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ISSUE_W-1:0]      in_slot_valid,
  input  logic [3*ISSUE_W-1:0]    in_op,
  input  logic [RAW*ISSUE_W-1:0]  in_rd,
  input  logic [RAW*ISSUE_W-1:0]  in_rs1,
  input  logic [RAW*ISSUE_W-1:0]  in_rs2,
  input  logic [XLEN*ISSUE_W-1:0] in_imm,
  output logic [RAW*ISSUE_W-1:0]  rf_raddr1,
  output logic [RAW*ISSUE_W-1:0]  rf_raddr2,
  input  logic [XLEN*ISSUE_W-1:0] rf_rdata1,
  input  logic [XLEN*ISSUE_W-1:0] rf_rdata2,
  input  logic [4*ISSUE_W-1:0]    fu_busy,
  input  logic [ISSUE_W-1:0]      wb_valid,
  input  logic [RAW*ISSUE_W-1:0]  wb_rd,
  input  logic [XLEN*ISSUE_W-1:0] wb_data,
  output logic [ISSUE_W-1:0]      issue_valid,
  output logic [3*ISSUE_W-1:0]    issue_op,
  output logic [RAW*ISSUE_W-1:0]  issue_rd,
  output logic [XLEN*ISSUE_W-1:0] issue_a,
  output logic [XLEN*ISSUE_W-1:0] issue_b,
  output logic [NUM_REGS-1:0]     sb_busy,
  output logic                    hazard_stall,
  output logic [31:0]             stall_count
);
  logic [ISSUE_W-1:0] pend, go, done;
  logic [ISSUE_W-1:0] writer, use1, use2, byp1, byp2, fu_block;
  logic [NUM_REGS-1:0] sb_d;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  assign pend = {ISSUE_W{in_valid & ~reset}} & in_slot_valid & ~done;

  // Older pending writers block a dependent slot even when they issue this cycle.
  always_comb begin
    logic order_ok, hz;
    logic [RAW-1:0] s1, s2, d, dj;
    order_ok = 1'b1;
    hz       = 1'b0;
    s1       = '0;
    s2       = '0;
    d        = '0;
    dj       = '0;
    go       = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      s1 = in_rs1[i*RAW +: RAW];
      s2 = in_rs2[i*RAW +: RAW];
      d  = in_rd[i*RAW +: RAW];
      hz = fu_block[i];
      if (use1[i] && s1 != '0 && sb_busy[s1] && !byp1[i]) hz = 1'b1;
      if (use2[i] && s2 != '0 && sb_busy[s2] && !byp2[i]) hz = 1'b1;
      if (writer[i] && d != '0 && sb_busy[d]) hz = 1'b1;
      for (int j = 0; j < i; j++) begin
        dj = in_rd[j*RAW +: RAW];
        if (pend[j] && writer[j] && dj != '0 &&
            ((use1[i] && s1 == dj) || (use2[i] && s2 == dj) || (writer[i] && d == dj)))
          hz = 1'b1;
      end
      go[i]    = pend[i] & order_ok & ~hz;
      order_ok = order_ok & (~pend[i] | go[i]);
    end
  end

  assign in_ready = in_valid & ~reset & (&(~pend | go));

  // Writeback clears first, then issuing writers set, so a set wins on collision.
  always_comb begin
    sb_d = sb_busy;
    for (int k = 0; k < ISSUE_W; k++)
      if (wb_valid[k]) sb_d[wb_rd[k*RAW +: RAW]] = 1'b0;
    for (int i = 0; i < ISSUE_W; i++)
      if (go[i] && writer[i] && in_rd[i*RAW +: RAW] != '0) sb_d[in_rd[i*RAW +: RAW]] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_busy      <= '0;
      done         <= '0;
      hazard_stall <= 1'b0;
      stall_count  <= '0;
    end else begin
      sb_busy      <= sb_d;
      done         <= in_ready ? '0 : (done | go);
      hazard_stall <= in_valid & ~in_ready;
      if (in_valid && !in_ready && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
    end
  end

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
    dispatch_issue_lane #(.ISSUE_W(ISSUE_W), .XLEN(XLEN), .RAW(RAW)) u_lane (
      .clk         (clk),
      .reset       (reset),
      .go          (go[i]),
      .op          (in_op[3*i +: 3]),
      .rd          (in_rd[RAW*i +: RAW]),
      .rs1         (in_rs1[RAW*i +: RAW]),
      .rs2         (in_rs2[RAW*i +: RAW]),
      .imm         (in_imm[XLEN*i +: XLEN]),
      .rdata1      (rf_rdata1[XLEN*i +: XLEN]),
      .rdata2      (rf_rdata2[XLEN*i +: XLEN]),
      .fu_busy     (fu_busy[4*i +: 4]),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .writer      (writer[i]),
      .use1        (use1[i]),
      .use2        (use2[i]),
      .byp1        (byp1[i]),
      .byp2        (byp2[i]),
      .fu_block    (fu_block[i]),
      .issue_valid (issue_valid[i]),
      .issue_op    (issue_op[3*i +: 3]),
      .issue_rd    (issue_rd[RAW*i +: RAW]),
      .issue_a     (issue_a[XLEN*i +: XLEN]),
      .issue_b     (issue_b[XLEN*i +: XLEN])
    );
  end
endmodule

// File: tb/tb_dispatch_issue_scoreboard.sv
// Scoreboard bench for dispatch_issue_scoreboard: expected issues queued per lane,
// a negedge monitor pops and compares; directed checks cover stalls and reset.
module tb_dispatch_issue_scoreboard;
  localparam int W = 2, XL = 32, RA = 5, NR = 32;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic in_valid, in_ready;
  logic [W-1:0] in_slot_valid, wb_valid, issue_valid;
  logic [3*W-1:0] in_op, issue_op;
  logic [RA*W-1:0] in_rd, in_rs1, in_rs2, rf_raddr1, rf_raddr2, wb_rd, issue_rd;
  logic [XL*W-1:0] in_imm, rf_rdata1, rf_rdata2, wb_data, issue_a, issue_b;
  logic [4*W-1:0] fu_busy;
  logic [NR-1:0] sb_busy;
  logic hazard_stall;
  logic [31:0] stall_count;

  dispatch_issue_scoreboard #(.ISSUE_W(W), .NUM_REGS(NR), .XLEN(XL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_slot_valid(in_slot_valid), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fu_busy(fu_busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .issue_valid(issue_valid),
    .issue_op(issue_op), .issue_rd(issue_rd), .issue_a(issue_a), .issue_b(issue_b),
    .sb_busy(sb_busy), .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  logic [31:0] rf [NR];
  always_comb begin
    rf_rdata1 = '0;
    rf_rdata2 = '0;
    for (int i = 0; i < W; i++) begin
      rf_rdata1[i*XL +: XL] = rf[rf_raddr1[i*RA +: RA]];
      rf_rdata2[i*XL +: XL] = rf[rf_raddr2[i*RA +: RA]];
    end
  end

  typedef logic [71:0] exp_t;  // {op, rd, a, b}
  exp_t q0[$], q1[$];
  int total = 0, bad = 0;
  logic byp_en;
  logic [31:0] s2;

  function automatic exp_t mk(input logic [2:0] op, input logic [4:0] rd,
                              input logic [31:0] a, input logic [31:0] b);
    return {op, rd, a, b};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t got, e;
    if (!reset) begin
      for (int l = 0; l < W; l++) begin
        if (issue_valid[l]) begin
          got = {issue_op[l*3 +: 3], issue_rd[l*RA +: RA], issue_a[l*XL +: XL], issue_b[l*XL +: XL]};
          if ((l == 0 ? q0.size() : q1.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_issue lane%0d: got %0h expected no issue", l, got);
          end else begin
            e = (l == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("issue_lane%0d", l), {24'd0, got}, {24'd0, e});
          end
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); endtask

  task automatic slot(input int i, input logic [2:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_slot_valid[i]    = 1'b1;
    in_op[i*3 +: 3]     = op;
    in_rd[i*RA +: RA]   = rd;
    in_rs1[i*RA +: RA]  = rs1;
    in_rs2[i*RA +: RA]  = rs2;
    in_imm[i*XL +: XL]  = imm;
  endtask

  task automatic wb(input int l, input logic [4:0] rd, input logic [31:0] d);
    wb_valid[l]         = 1'b1;
    wb_rd[l*RA +: RA]   = rd;
    wb_data[l*XL +: XL] = d;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_slot_valid = '0; in_op = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
`ifdef WB_BYPASS_EN
    byp_en = 1'b1;
`else
    byp_en = 1'b0;
`endif
    s2 = byp_en ? 32'd2 : 32'd3;
    idle();
    fu_busy = '0; wb_valid = '0; wb_rd = '0; wb_data = '0;
    for (int i = 0; i < NR; i++) rf[i] = '0;
    rf[1] = 5; rf[2] = 7; rf[5] = 3; rf[6] = 4;
    rf[12] = 32'h100; rf[13] = 32'hDEAD; rf[15] = 32'hFFFF_FFFF;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_sb_busy", sb_busy, 0);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_count", stall_count, 0);
    chk("rst_ready", in_ready, 0);
    tick(); reset = 1'b0;

    // Two independent writers issue together
    tick(); slot(0, 1, 3, 1, 2, 0); slot(1, 2, 4, 5, 6, 0); in_valid = 1'b1;
    q0.push_back(mk(1, 3, 5, 7)); q1.push_back(mk(2, 4, 3, 4));
    mid(); chk("t1_ready", in_ready, 1);
    tick(); idle();
    mid(); chk("t1_sb", sb_busy, 32'h18);
    tick(); wb(0, 3, 0); wb(1, 4, 0);
    tick(); wb_valid = '0;
    mid(); chk("t1_sb_clear", sb_busy, 0);

    // Intra-bundle RAW on x3
    tick(); rf[3] = 100; slot(0, 1, 3, 1, 2, 0); slot(1, 1, 7, 1, 3, 0); in_valid = 1'b1;
    q0.push_back(mk(1, 3, 5, 7)); q1.push_back(mk(1, 7, 5, 12));
    mid(); chk("t2_c0_ready", in_ready, 0);
    tick();
    mid(); chk("t2_c1_hazard", hazard_stall, 1); chk("t2_c1_count", stall_count, 1);
    chk("t2_c1_sb3", sb_busy[3], 1);
    tick(); wb(0, 3, 12);
    mid(); chk("t2_c2_ready", in_ready, byp_en);
    tick(); wb_valid = '0; rf[3] = 12;
    if (!byp_en) tick();
    idle();
    mid(); chk("t2_count", stall_count, s2); chk("t2_sb", sb_busy, 32'h80);
    tick(); wb(0, 7, 0);
    tick(); wb_valid = '0;

    // In-order: slot0 MUL held by busy unit, independent slot1 must wait too
    tick(); slot(0, 2, 10, 5, 6, 0); slot(1, 1, 11, 1, 2, 0); in_valid = 1'b1; fu_busy = 8'h02;
    q0.push_back(mk(2, 10, 3, 4)); q1.push_back(mk(1, 11, 5, 7));
    mid(); chk("t3_c0_ready", in_ready, 0);
    tick(); tick();
    mid(); chk("t3_c2_hazard", hazard_stall, 1);
    tick(); fu_busy = '0;
    mid(); chk("t3_c3_ready", in_ready, 1); chk("t3_c3_hazard", hazard_stall, 1);
    tick(); idle();
    mid(); chk("t3_hazard_low", hazard_stall, 0); chk("t3_count", stall_count, s2 + 3);
    chk("t3_sb", sb_busy, (32'h1 << 10) | (32'h1 << 11));
    tick(); wb(0, 10, 0); wb(1, 11, 0);
    tick(); wb_valid = '0;

    // STORE address add, LOAD wrap-around
    tick(); slot(0, 4, 5, 12, 13, 32'h10); slot(1, 3, 14, 15, 0, 2); in_valid = 1'b1;
    q0.push_back(mk(4, 5, 32'h110, 32'hDEAD)); q1.push_back(mk(3, 14, 1, 0));
    mid(); chk("t4_ready", in_ready, 1);
    tick(); idle();
    mid(); chk("t4_sb", sb_busy, 32'h1 << 14);
    tick(); wb(0, 14, 0);
    tick(); wb_valid = '0;

    // Set beats same-cycle clear on x9; rd=0 never tracked
    tick(); slot(0, 1, 9, 1, 2, 0); in_valid = 1'b1;
    q0.push_back(mk(1, 9, 5, 7));
    tick(); idle();
    mid(); chk("t5_sb9_set", sb_busy, 32'h1 << 9);
    tick(); wb(0, 9, 0);
    tick(); slot(0, 1, 9, 1, 2, 0); slot(1, 1, 0, 1, 2, 0); in_valid = 1'b1;
    q0.push_back(mk(1, 9, 5, 7)); q1.push_back(mk(1, 0, 5, 7));
    mid(); chk("t5_ready", in_ready, 1); chk("t5_sb_cleared", sb_busy, 0);
    tick(); idle(); wb_valid = '0;
    mid(); chk("t5_set_wins", sb_busy, 32'h1 << 9);
    tick(); wb(0, 9, 0);
    tick(); wb_valid = '0;

    // Reset while slot1 pending after slot0 issued
    tick(); slot(0, 1, 16, 1, 2, 0); slot(1, 1, 17, 1, 2, 0); in_valid = 1'b1; fu_busy = 8'h10;
    q0.push_back(mk(1, 16, 5, 7));
    mid(); chk("t6_c0_ready", in_ready, 0);
    tick();
    mid();
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_issue_valid", issue_valid, 0);
    chk("t6_rst_sb", sb_busy, 0);
    chk("t6_rst_hazard", hazard_stall, 0);
    chk("t6_rst_count", stall_count, 0);
    chk("t6_rst_ready", in_ready, 0);
    fu_busy = '0;
    q0.push_back(mk(1, 16, 5, 7)); q1.push_back(mk(1, 17, 5, 7));
    tick(); tick(); reset = 1'b0;
    mid(); chk("t6_reissue_ready", in_ready, 1);
    tick(); idle();
    mid(); chk("t6_sb", sb_busy, (32'h1 << 16) | (32'h1 << 17));

    tick(); tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
